// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command driver: op-group and op encodings,
// instruction-word field positions, the command record and the FSM states.
package alu_pkg;

    typedef enum logic [1:0] {
        GRP_ARITH   = 2'd0,
        GRP_LOGIC   = 2'd1,
        GRP_ZERO    = 2'd2,
        GRP_SPECIAL = 2'd3
    } grp_e;

    // Ops within the arithmetic/shift group
    localparam logic [1:0] OP_SHR   = 2'd0;
    localparam logic [1:0] OP_SHL   = 2'd1;
    localparam logic [1:0] OP_ADD   = 2'd2;
    localparam logic [1:0] OP_SUB   = 2'd3;

    // Ops within the logic group
    localparam logic [1:0] OP_AND   = 2'd0;
    localparam logic [1:0] OP_OR    = 2'd1;
    localparam logic [1:0] OP_XOR   = 2'd2;
    localparam logic [1:0] OP_CONST = 2'd3;

    // Instruction word layout; bits below OP_LSB are always zero
    localparam int DST_MSB = 15;
    localparam int DST_LSB = 14;
    localparam int GRP_MSB = 13;
    localparam int GRP_LSB = 12;
    localparam int OP_MSB  = 11;
    localparam int OP_LSB  = 10;

    typedef struct packed {
        grp_e       grp;
        logic [1:0] op;
        logic [1:0] dst;
        logic [7:0] a;
        logic [7:0] b;
    } alu_cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    // Packs a command into the 16-bit ALU instruction word
    function automatic logic [15:0] encode_instr(input alu_cmd_t cmd);
        logic [15:0] word;
        word = 16'h0000;
        word[DST_MSB:DST_LSB] = cmd.dst;
        word[GRP_MSB:GRP_LSB] = cmd.grp;
        word[OP_MSB:OP_LSB]   = cmd.op;
        return word;
    endfunction

endpackage

// File: rtl/alu_golden_model.sv
// Combinational reference for the 8-bit ALU. Produces the expected result for
// a group/op/operand set; special-group ops have no reference value.
module alu_golden_model
    import alu_pkg::*;
(
    input  logic [1:0] grp,
    input  logic [1:0] op,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] expected,
    output logic       check_en
);

    // Shift amounts of eight or more clear the operand entirely
    always_comb begin
        expected = 8'h00;
        check_en = 1'b1;
        case (grp_e'(grp))
            GRP_ARITH: begin
                case (op)
                    OP_SHR:  expected = (b >= 8'd8) ? 8'h00 : (a >> b[2:0]);
                    OP_SHL:  expected = (b >= 8'd8) ? 8'h00 : (a << b[2:0]);
                    OP_ADD:  expected = a + b;
                    default: expected = a - b;
                endcase
            end
            GRP_LOGIC: begin
                case (op)
                    OP_AND:  expected = a & b;
                    OP_OR:   expected = a | b;
                    OP_XOR:  expected = a ^ b;
                    default: expected = 8'h01;
                endcase
            end
            GRP_ZERO: expected = 8'h00;
            default:  check_en = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_driver.sv
// Command-side initiator for the combinational 8-bit ALU. Accepts one command,
// drives the ALU for SETTLE_CYCLES cycles, captures the routed output plus
// flags and hands them back over a valid/ready response channel.
// Optional self-check: define ALU_DRIVER_CHECK_EN to add chk_err and
// chk_err_sticky, driven from alu_golden_model.
module alu_driver
    import alu_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_grp,
    input  logic [1:0]  cmd_op,
    input  logic [1:0]  cmd_dst,
    input  logic [7:0]  cmd_a,
    input  logic [7:0]  cmd_b,
    output logic [15:0] alu_instruction,
    output logic [7:0]  alu_data0,
    output logic [7:0]  alu_data1,
    input  logic [7:0]  alu_out0,
    input  logic [7:0]  alu_out1,
    input  logic [7:0]  alu_out2,
    input  logic [7:0]  alu_out3,
    input  logic        alu_of,
    input  logic        alu_zf,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [7:0]  rsp_result,
    output logic        rsp_of,
    output logic        rsp_zf,
`ifdef ALU_DRIVER_CHECK_EN
    output logic        chk_err,
    output logic        chk_err_sticky,
`endif
    output logic [1:0]  rsp_dst
);

    localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] instr_q, instr_d;
    logic [7:0]  data0_q, data0_d;
    logic [7:0]  data1_q, data1_d;
    logic [7:0]  rsp_result_q, rsp_result_d;
    logic        rsp_of_q, rsp_of_d;
    logic        rsp_zf_q, rsp_zf_d;
    logic [1:0]  rsp_dst_q, rsp_dst_d;

    alu_cmd_t    cmd;
    logic [1:0]  cur_dst;
    logic [1:0]  cur_grp;
    logic [1:0]  cur_op;
    logic [7:0]  sel_out;
    logic        capture;

    assign cmd = '{grp: grp_e'(cmd_grp), op: cmd_op, dst: cmd_dst, a: cmd_a, b: cmd_b};

    // The operation in flight is recovered from the instruction word being driven
    assign cur_dst = instr_q[DST_MSB:DST_LSB];
    assign cur_grp = instr_q[GRP_MSB:GRP_LSB];
    assign cur_op  = instr_q[OP_MSB:OP_LSB];

    // Route the ALU output port named by the in-flight destination
    always_comb begin
        sel_out = alu_out0;
        case (cur_dst)
            2'd0:    sel_out = alu_out0;
            2'd1:    sel_out = alu_out1;
            2'd2:    sel_out = alu_out2;
            default: sel_out = alu_out3;
        endcase
    end

    // Next-state logic: accept in IDLE, count down in SETTLE, hold in RESP until taken
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        instr_d      = instr_q;
        data0_d      = data0_q;
        data1_d      = data1_q;
        rsp_result_d = rsp_result_q;
        rsp_of_d     = rsp_of_q;
        rsp_zf_d     = rsp_zf_q;
        rsp_dst_d    = rsp_dst_q;
        capture      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    instr_d = encode_instr(cmd);
                    data0_d = cmd.a;
                    data1_d = cmd.b;
                    cnt_d   = CNT_LOAD;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == 4'd0) begin
                    capture = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (capture) begin
            rsp_result_d = sel_out;
            rsp_zf_d     = alu_zf;
            rsp_dst_d    = cur_dst;
            rsp_of_d     = (cur_grp == GRP_ARITH && cur_op == OP_ADD) ? alu_of : 1'b0;
        end
    end

    // State, ALU drive and response registers; reset abandons any op in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            instr_q      <= 16'h0000;
            data0_q      <= 8'h00;
            data1_q      <= 8'h00;
            rsp_result_q <= 8'h00;
            rsp_of_q     <= 1'b0;
            rsp_zf_q     <= 1'b0;
            rsp_dst_q    <= 2'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            instr_q      <= instr_d;
            data0_q      <= data0_d;
            data1_q      <= data1_d;
            rsp_result_q <= rsp_result_d;
            rsp_of_q     <= rsp_of_d;
            rsp_zf_q     <= rsp_zf_d;
            rsp_dst_q    <= rsp_dst_d;
        end
    end

    assign cmd_ready       = (state_q == ST_IDLE);
    assign rsp_valid       = (state_q == ST_RESP);
    assign alu_instruction = instr_q;
    assign alu_data0       = data0_q;
    assign alu_data1       = data1_q;
    assign rsp_result      = rsp_result_q;
    assign rsp_of          = rsp_of_q;
    assign rsp_zf          = rsp_zf_q;
    assign rsp_dst         = rsp_dst_q;

`ifdef ALU_DRIVER_CHECK_EN
    logic [7:0] gold_result;
    logic       gold_check;
    logic       chk_err_q, chk_err_d;
    logic       chk_sticky_q, chk_sticky_d;

    alu_golden_model u_golden (
        .grp      (cur_grp),
        .op       (cur_op),
        .a        (data0_q),
        .b        (data1_q),
        .expected (gold_result),
        .check_en (gold_check)
    );

    // Judge the captured value against the model and the zero-flag consistency rule
    always_comb begin
        chk_err_d    = chk_err_q;
        chk_sticky_d = chk_sticky_q;
        if (capture) begin
            chk_err_d    = (gold_check && (sel_out != gold_result)) ||
                           (alu_zf != (sel_out == 8'h00));
            chk_sticky_d = chk_sticky_q | chk_err_d;
        end
    end

    // Check flags; the sticky copy is only ever cleared by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chk_err_q    <= 1'b0;
            chk_sticky_q <= 1'b0;
        end else begin
            chk_err_q    <= chk_err_d;
            chk_sticky_q <= chk_sticky_d;
        end
    end

    assign chk_err        = chk_err_q & rsp_valid;
    assign chk_err_sticky = chk_sticky_q;
`endif

endmodule

// File: tb/tb_alu_driver.sv
// Bench for alu_driver: two instances (SETTLE_CYCLES 1 and 4) each driving a
// behavioural ALU stub, selected through a shared command/response interface.
module tb_alu_driver;

    typedef struct packed {
        logic [7:0] o0;
        logic [7:0] o1;
        logic [7:0] o2;
        logic [7:0] o3;
        logic       of;
        logic       zf;
    } stub_t;

    typedef struct {
        logic [1:0]  grp;
        logic [1:0]  op;
        logic [1:0]  dst;
        logic [7:0]  a;
        logic [7:0]  b;
        logic        force_of;
        logic [15:0] exp_instr;
        logic [7:0]  exp_result;
        logic        exp_of;
        logic        exp_zf;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        rsp_ready = 1'b0;
    logic [1:0]  cmd_grp = 2'd0;
    logic [1:0]  cmd_op = 2'd0;
    logic [1:0]  cmd_dst = 2'd0;
    logic [7:0]  cmd_a = 8'h00;
    logic [7:0]  cmd_b = 8'h00;
    logic        corrupt_and = 1'b0;
    logic        force_of = 1'b0;

    logic        cmd_ready_w [2];
    logic        rsp_valid_w [2];
    logic [15:0] instr_w [2];
    logic [7:0]  data0_w [2];
    logic [7:0]  data1_w [2];
    logic [7:0]  result_w [2];
    logic        of_w [2];
    logic        zf_w [2];
    logic [1:0]  dst_w [2];
    stub_t       stub_w [2];
`ifdef ALU_DRIVER_CHECK_EN
    logic        chk_err_w [2];
    logic        chk_sticky_w [2];
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Behavioural ALU: selected port gets the result, the others its complement
    function automatic stub_t stub_alu(input logic [15:0] instr, input logic [7:0] a,
                                       input logic [7:0] b, input logic corrupt,
                                       input logic frc_of);
        stub_t s;
        logic [7:0] r;
        logic ovf;
        r = 8'h00;
        ovf = 1'b0;
        case (instr[13:12])
            2'd0: case (instr[11:10])
                2'd0: r = (b >= 8'd8) ? 8'h00 : (a >> b[2:0]);
                2'd1: r = (b >= 8'd8) ? 8'h00 : (a << b[2:0]);
                2'd2: begin r = a + b; ovf = (a[7] == b[7]) && (r[7] != a[7]); end
                default: begin r = a - b; ovf = (a[7] != b[7]) && (r[7] != a[7]); end
            endcase
            2'd1: case (instr[11:10])
                2'd0: r = corrupt ? ((a & b) ^ 8'h01) : (a & b);
                2'd1: r = a | b;
                2'd2: r = a ^ b;
                default: r = 8'h01;
            endcase
            2'd2: r = 8'h00;
            default: r = {7'b0, a == b};
        endcase
        s.o0 = ~r; s.o1 = ~r; s.o2 = ~r; s.o3 = ~r;
        case (instr[15:14])
            2'd0: s.o0 = r;
            2'd1: s.o1 = r;
            2'd2: s.o2 = r;
            default: s.o3 = r;
        endcase
        s.of = ovf | frc_of;
        s.zf = (r == 8'h00);
        return s;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        always_comb stub_w[g] = stub_alu(instr_w[g], data0_w[g], data1_w[g], corrupt_and, force_of);

        alu_driver #(.SETTLE_CYCLES(g == 0 ? 1 : 4)) u_dut (
            .clk             (clk),
            .rst             (rst),
            .cmd_valid       (cmd_valid && (sel == 1'(g))),
            .cmd_ready       (cmd_ready_w[g]),
            .cmd_grp         (cmd_grp),
            .cmd_op          (cmd_op),
            .cmd_dst         (cmd_dst),
            .cmd_a           (cmd_a),
            .cmd_b           (cmd_b),
            .alu_instruction (instr_w[g]),
            .alu_data0       (data0_w[g]),
            .alu_data1       (data1_w[g]),
            .alu_out0        (stub_w[g].o0),
            .alu_out1        (stub_w[g].o1),
            .alu_out2        (stub_w[g].o2),
            .alu_out3        (stub_w[g].o3),
            .alu_of          (stub_w[g].of),
            .alu_zf          (stub_w[g].zf),
            .rsp_valid       (rsp_valid_w[g]),
            .rsp_ready       (rsp_ready && (sel == 1'(g))),
            .rsp_result      (result_w[g]),
            .rsp_of          (of_w[g]),
            .rsp_zf          (zf_w[g]),
`ifdef ALU_DRIVER_CHECK_EN
            .chk_err         (chk_err_w[g]),
            .chk_err_sticky  (chk_sticky_w[g]),
`endif
            .rsp_dst         (dst_w[g])
        );
    end

    // Sample and drive one time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkIdleReset(input string name);
        checkOutput({name, ".cmd_ready"}, 16'(cmd_ready_w[sel]), 16'd1);
        checkOutput({name, ".rsp_valid"}, 16'(rsp_valid_w[sel]), 16'd0);
        checkOutput({name, ".instr"}, instr_w[sel], 16'h0000);
        checkOutput({name, ".data"}, {data0_w[sel], data1_w[sel]}, 16'h0000);
        checkOutput({name, ".rsp"}, {4'h0, result_w[sel], of_w[sel], zf_w[sel], dst_w[sel]}, 16'h0000);
    endtask

    // Present one command, wait for its acceptance and for the response to appear
    task automatic applyStimulus(input vec_t v, input int exp_lat, input string name);
        int n;
        cmd_grp = v.grp; cmd_op = v.op; cmd_dst = v.dst;
        cmd_a = v.a; cmd_b = v.b; force_of = v.force_of;
        rsp_ready = 1'b1;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready_w[sel] && n < 30) begin tick(); n++; end
        if (!cmd_ready_w[sel]) checkOutput({name, ".accept_timeout"}, 16'd0, 16'd1);
        tick();
        cmd_valid = 1'b0;
        checkOutput({name, ".instr"}, instr_w[sel], v.exp_instr);
        checkOutput({name, ".data"}, {data0_w[sel], data1_w[sel]}, {v.a, v.b});
        checkOutput({name, ".busy"}, 16'(cmd_ready_w[sel]), 16'd0);
        n = 0;
        while (!rsp_valid_w[sel] && n < 40) begin tick(); n++; end
        checkOutput({name, ".latency"}, 16'(n), 16'(exp_lat));
    endtask

    task automatic checkResponse(input vec_t v, input string name);
        checkOutput({name, ".result"}, {8'h00, result_w[sel]}, {8'h00, v.exp_result});
        checkOutput({name, ".of"}, 16'(of_w[sel]), 16'(v.exp_of));
        checkOutput({name, ".zf"}, 16'(zf_w[sel]), 16'(v.exp_zf));
        checkOutput({name, ".dst"}, 16'(dst_w[sel]), 16'(v.dst));
    endtask

    task automatic finishResponse(input string name);
        tick();
        checkOutput({name, ".rsp_drop"}, 16'(rsp_valid_w[sel]), 16'd0);
        checkOutput({name, ".ready_back"}, 16'(cmd_ready_w[sel]), 16'd1);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vecs [16];
        vec_t v;
        int n;
        int cyc;
        int nacc;
        int nres;
        int acc_cyc [2];
        logic [7:0] res [2];
        logic acc;
        logic seen;

        vecs[0]  = '{2'd0, 2'd2, 2'd2, 8'hF0, 8'h20, 1'b0, 16'h8800, 8'h10, 1'b0, 1'b0};
        vecs[1]  = '{2'd1, 2'd2, 2'd0, 8'h5A, 8'h5A, 1'b1, 16'h1800, 8'h00, 1'b0, 1'b1};
        vecs[2]  = '{2'd0, 2'd2, 2'd1, 8'h70, 8'h10, 1'b0, 16'h4800, 8'h80, 1'b1, 1'b0};
        vecs[3]  = '{2'd0, 2'd2, 2'd3, 8'hFF, 8'h01, 1'b0, 16'hC800, 8'h00, 1'b0, 1'b1};
        vecs[4]  = '{2'd0, 2'd0, 2'd3, 8'h80, 8'h03, 1'b0, 16'hC000, 8'h10, 1'b0, 1'b0};
        vecs[5]  = '{2'd0, 2'd0, 2'd0, 8'hFF, 8'h09, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b1};
        vecs[6]  = '{2'd0, 2'd1, 2'd1, 8'h81, 8'h01, 1'b0, 16'h4400, 8'h02, 1'b0, 1'b0};
        vecs[7]  = '{2'd0, 2'd1, 2'd2, 8'h01, 8'h08, 1'b0, 16'h8400, 8'h00, 1'b0, 1'b1};
        vecs[8]  = '{2'd0, 2'd3, 2'd0, 8'h03, 8'h05, 1'b0, 16'h0C00, 8'hFE, 1'b0, 1'b0};
        vecs[9]  = '{2'd0, 2'd3, 2'd2, 8'h80, 8'h01, 1'b0, 16'h8C00, 8'h7F, 1'b0, 1'b0};
        vecs[10] = '{2'd1, 2'd0, 2'd3, 8'hF0, 8'h3C, 1'b0, 16'hD000, 8'h30, 1'b0, 1'b0};
        vecs[11] = '{2'd1, 2'd1, 2'd1, 8'h0F, 8'hF0, 1'b0, 16'h5400, 8'hFF, 1'b0, 1'b0};
        vecs[12] = '{2'd1, 2'd3, 2'd2, 8'h12, 8'h34, 1'b0, 16'h9C00, 8'h01, 1'b0, 1'b0};
        vecs[13] = '{2'd2, 2'd1, 2'd1, 8'h12, 8'h34, 1'b0, 16'h6400, 8'h00, 1'b0, 1'b1};
        vecs[14] = '{2'd3, 2'd0, 2'd0, 8'h77, 8'h77, 1'b0, 16'h3000, 8'h01, 1'b0, 1'b0};
        vecs[15] = '{2'd3, 2'd2, 2'd3, 8'h01, 8'h02, 1'b0, 16'hF800, 8'h00, 1'b0, 1'b1};

        // Reset values on both instances
        tick();
        tick();
        sel = 1'b0;
        checkIdleReset("reset.s1");
        sel = 1'b1;
        checkIdleReset("reset.s4");
        rst = 1'b0;
        tick();

        // Table-driven pass on the single-cycle-settle instance
        sel = 1'b0;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i], 1, $sformatf("v%0d", i));
            checkResponse(vecs[i], $sformatf("v%0d", i));
`ifdef ALU_DRIVER_CHECK_EN
            checkOutput($sformatf("v%0d.chk_err", i), 16'(chk_err_w[0]), 16'd0);
`endif
            finishResponse($sformatf("v%0d", i));
        end
        force_of = 1'b0;

        // Four-cycle settle with the response stalled while a second command waits
        sel = 1'b1;
        v = '{2'd0, 2'd2, 2'd1, 8'h11, 8'h22, 1'b0, 16'h4800, 8'h33, 1'b0, 1'b0};
        cmd_grp = v.grp; cmd_op = v.op; cmd_dst = v.dst; cmd_a = v.a; cmd_b = v.b;
        rsp_ready = 1'b0;
        cmd_valid = 1'b1;
        tick();
        cmd_grp = 2'd1; cmd_op = 2'd1; cmd_dst = 2'd3; cmd_a = 8'h0F; cmd_b = 8'hF0;
        checkOutput("stall.instr", instr_w[1], 16'h4800);
        n = 0;
        while (!rsp_valid_w[1] && n < 40) begin
            if (cmd_ready_w[1]) checkOutput("stall.settle_ready", 16'd1, 16'd0);
            tick();
            n++;
        end
        checkOutput("stall.latency", 16'(n), 16'd4);
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (!rsp_valid_w[1] || cmd_ready_w[1] || result_w[1] != 8'h33 ||
                dst_w[1] != 2'd1 || zf_w[1] || of_w[1] || instr_w[1] != 16'h4800) seen = 1'b1;
            tick();
        end
        checkOutput("stall.hold_stable", 16'(seen), 16'd0);
        checkResponse(v, "stall");
        rsp_ready = 1'b1;
        tick();
        checkOutput("stall.rsp_drop", 16'(rsp_valid_w[1]), 16'd0);
        checkOutput("stall.ready_back", 16'(cmd_ready_w[1]), 16'd1);
        checkOutput("stall.no_overlap", instr_w[1], 16'h4800);
        tick();
        cmd_valid = 1'b0;
        checkOutput("stall.second_instr", instr_w[1], 16'hD400);
        checkOutput("stall.second_busy", 16'(cmd_ready_w[1]), 16'd0);
        n = 0;
        while (!rsp_valid_w[1] && n < 40) begin tick(); n++; end
        checkOutput("stall.second_latency", 16'(n), 16'd4);
        checkOutput("stall.second_result", {8'h00, result_w[1]}, 16'h00FF);
        checkOutput("stall.second_dst", 16'(dst_w[1]), 16'd3);
        finishResponse("stall.second");

        // Reset asserted two cycles into the settle window
        cmd_grp = 2'd0; cmd_op = 2'd3; cmd_dst = 2'd0; cmd_a = 8'h03; cmd_b = 8'h05;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        checkIdleReset("midrst");
        tick();
        rst = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (rsp_valid_w[1]) seen = 1'b1;
            tick();
        end
        checkOutput("midrst.no_rsp", 16'(seen), 16'd0);
        applyStimulus(vecs[8], 4, "midrst.next");
        checkResponse(vecs[8], "midrst.next");
        finishResponse("midrst.next");

        // Back-to-back sub then shl with the response always taken
        sel = 1'b0;
        rsp_ready = 1'b1;
        cmd_grp = 2'd0; cmd_op = 2'd3; cmd_dst = 2'd0; cmd_a = 8'h03; cmd_b = 8'h05;
        cmd_valid = 1'b1;
        cyc = 0; nacc = 0; nres = 0;
        acc_cyc[0] = 0; acc_cyc[1] = 0; res[0] = 8'h00; res[1] = 8'h00;
        while (nres < 2 && cyc < 30) begin
            if (rsp_valid_w[0]) begin res[nres] = result_w[0]; nres++; end
            acc = cmd_valid && cmd_ready_w[0];
            tick();
            cyc++;
            if (acc && nacc < 2) begin
                acc_cyc[nacc] = cyc;
                nacc++;
                if (nacc == 1) begin
                    cmd_op = 2'd1; cmd_dst = 2'd1; cmd_a = 8'h81; cmd_b = 8'h01;
                end else begin
                    cmd_valid = 1'b0;
                end
            end
        end
        cmd_valid = 1'b0;
        checkOutput("b2b.responses", 16'(nres), 16'd2);
        checkOutput("b2b.period", 16'(acc_cyc[1] - acc_cyc[0]), 16'd3);
        checkOutput("b2b.sub", {8'h00, res[0]}, 16'h00FE);
        checkOutput("b2b.shl", {8'h00, res[1]}, 16'h0002);
        tick();

`ifdef ALU_DRIVER_CHECK_EN
        // Corrupted AND from the stub must raise the check flags
        v = vecs[10];
        v.exp_result = 8'h31;
        corrupt_and = 1'b1;
        applyStimulus(v, 1, "chk.bad");
        checkResponse(v, "chk.bad");
        checkOutput("chk.bad.err", 16'(chk_err_w[0]), 16'd1);
        checkOutput("chk.bad.sticky", 16'(chk_sticky_w[0]), 16'd1);
        finishResponse("chk.bad");
        corrupt_and = 1'b0;
        applyStimulus(vecs[11], 1, "chk.good");
        checkOutput("chk.good.err", 16'(chk_err_w[0]), 16'd0);
        checkOutput("chk.good.sticky", 16'(chk_sticky_w[0]), 16'd1);
        finishResponse("chk.good");
        rst = 1'b1;
        #1;
        checkOutput("chk.rst.sticky", 16'(chk_sticky_w[0]), 16'd0);
        tick();
        rst = 1'b0;
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
